// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported data memory between the core
// load/store unit (port 0) and an external loader/debug agent (port 1).
// Each access walks IDLE -> ISSUE -> RESP: the request is latched in IDLE,
// the memory strobe fires in ISSUE, and the requester is acked in RESP.
module dmem_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter bit RR_EN  = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    // port 0: core load/store unit
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    output logic              p0_stall,
    // port 1: external loader / debug agent
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic              p1_stall,
    // data memory side
    output logic              wr,
    output logic              rd,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] wr_data,
    input  logic [DATA_W-1:0] rd_data,
    // status
    output logic              busy,
    output logic              grant_id
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ISSUE = 2'b01,
        ST_RESP  = 2'b10
    } state_t;

    state_t              state_r;
    state_t              state_nxt_s;

    logic                grant_s;
    logic                win_s;
    logic                sel_we_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;
    logic                rd_ret0_s;
    logic                rd_ret1_s;

    logic                grant_id_r;
    logic                last_grant_r;
    logic                we_r;
    logic                wr_r;
    logic                rd_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wr_data_r;
    logic                ack0_r;
    logic                ack1_r;
    logic [DATA_W-1:0]   rdata0_r;
    logic [DATA_W-1:0]   rdata1_r;

    // Arbitration: pick a winner among pending ports; ties go round-robin or to port 0
    always_comb begin
        grant_s = 1'b0;
        win_s   = 1'b0;
        if (p0_req && p1_req) begin
            grant_s = 1'b1;
            if (RR_EN == 1'b1) begin
                win_s = ~last_grant_r;
            end else begin
                win_s = 1'b0;
            end
        end else if (p0_req) begin
            grant_s = 1'b1;
            win_s   = 1'b0;
        end else if (p1_req) begin
            grant_s = 1'b1;
            win_s   = 1'b1;
        end else begin
            grant_s = 1'b0;
            win_s   = 1'b0;
        end
    end

    // Command mux: route the winning port's command towards the latch
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        if (win_s) begin
            sel_we_s    = p1_we;
            sel_addr_s  = p1_addr;
            sel_wdata_s = p1_wdata;
        end else begin
            sel_we_s    = p0_we;
            sel_addr_s  = p0_addr;
            sel_wdata_s = p0_wdata;
        end
    end

    // Next-state logic: ISSUE and RESP each last exactly one cycle
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_s) begin
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: state_nxt_s = ST_RESP;
            ST_RESP:  state_nxt_s = ST_IDLE;
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // State register; async reset aborts any access in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Command latch: capture owner and command of the winner when leaving IDLE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant_id_r <= 1'b0;
            we_r       <= 1'b0;
            addr_r     <= '0;
            wr_data_r  <= '0;
        end else if ((state_r == ST_IDLE) && grant_s) begin
            grant_id_r <= win_s;
            we_r       <= sel_we_s;
            addr_r     <= sel_addr_s;
            wr_data_r  <= sel_wdata_s;
        end
    end

    // Memory strobes: exactly one of wr/rd is high for the ISSUE cycle only
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_r <= 1'b0;
            rd_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && grant_s) begin
            wr_r <= sel_we_s;
            rd_r <= ~sel_we_s;
        end else begin
            wr_r <= 1'b0;
            rd_r <= 1'b0;
        end
    end

    // Fairness memory: resets to 1 so port 0 wins the first tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_r <= 1'b1;
        end else if (state_r == ST_ISSUE) begin
            last_grant_r <= grant_id_r;
        end
    end

    // Ack pulses: raised for the RESP cycle towards the owning port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
        end else if (state_r == ST_ISSUE) begin
            ack0_r <= ~grant_id_r;
            ack1_r <= grant_id_r;
        end else begin
            ack0_r <= 1'b0;
            ack1_r <= 1'b0;
        end
    end

    // Memory data returns during RESP of a read; route it to the owner
    assign rd_ret0_s = (state_r == ST_RESP) && !we_r && !grant_id_r;
    assign rd_ret1_s = (state_r == ST_RESP) && !we_r &&  grant_id_r;

    // Read data holding registers: keep the last read result per port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            if (rd_ret0_s) begin
                rdata0_r <= rd_data;
            end
            if (rd_ret1_s) begin
                rdata1_r <= rd_data;
            end
        end
    end

    // rdata is visible in the ack cycle itself, then held by the register
    assign p0_rdata = rd_ret0_s ? rd_data : rdata0_r;
    assign p1_rdata = rd_ret1_s ? rd_data : rdata1_r;

    assign p0_ack   = ack0_r;
    assign p1_ack   = ack1_r;
    assign p0_stall = p0_req & ~ack0_r;
    assign p1_stall = p1_req & ~ack1_r;

    assign wr       = wr_r;
    assign rd       = rd_r;
    assign addr     = addr_r;
    assign wr_data  = wr_data_r;
    assign busy     = (state_r != ST_IDLE);
    assign grant_id = grant_id_r;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed bench for dmem_arbiter. Instance "a" runs
// round-robin with a memory model, instance "b" runs fixed priority.
// Expected acks are queued when a request is issued and checked by a monitor.
module tb_dmem_arbiter;

    logic        clk;
    logic        reset;

    logic        a_p0_req, a_p0_we, a_p0_ack, a_p0_stall;
    logic [8:0]  a_p0_addr;
    logic [31:0] a_p0_wdata, a_p0_rdata;
    logic        a_p1_req, a_p1_we, a_p1_ack, a_p1_stall;
    logic [8:0]  a_p1_addr;
    logic [31:0] a_p1_wdata, a_p1_rdata;
    logic        a_wr, a_rd, a_busy, a_grant_id;
    logic [8:0]  a_addr;
    logic [31:0] a_wr_data, a_rd_data;

    logic        b_p0_req, b_p0_we, b_p0_ack, b_p0_stall;
    logic [8:0]  b_p0_addr;
    logic [31:0] b_p0_wdata, b_p0_rdata;
    logic        b_p1_req, b_p1_we, b_p1_ack, b_p1_stall;
    logic [8:0]  b_p1_addr;
    logic [31:0] b_p1_wdata, b_p1_rdata;
    logic        b_wr, b_rd, b_busy, b_grant_id;
    logic [8:0]  b_addr;
    logic [31:0] b_wr_data, b_rd_data;

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    exp_t        ea;
    exp_t        eb;
    int          checks;
    int          errors;
    int          cyc;
    logic [31:0] mem [0:511];

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RR_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset),
        .p0_req(a_p0_req), .p0_we(a_p0_we), .p0_addr(a_p0_addr), .p0_wdata(a_p0_wdata),
        .p0_ack(a_p0_ack), .p0_rdata(a_p0_rdata), .p0_stall(a_p0_stall),
        .p1_req(a_p1_req), .p1_we(a_p1_we), .p1_addr(a_p1_addr), .p1_wdata(a_p1_wdata),
        .p1_ack(a_p1_ack), .p1_rdata(a_p1_rdata), .p1_stall(a_p1_stall),
        .wr(a_wr), .rd(a_rd), .addr(a_addr), .wr_data(a_wr_data), .rd_data(a_rd_data),
        .busy(a_busy), .grant_id(a_grant_id)
    );

    dmem_arbiter #(.DATA_W(32), .ADDR_W(9), .RR_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata), .p0_stall(b_p0_stall),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata), .p1_stall(b_p1_stall),
        .wr(b_wr), .rd(b_rd), .addr(b_addr), .wr_data(b_wr_data), .rd_data(b_rd_data),
        .busy(b_busy), .grant_id(b_grant_id)
    );

    // Clock generation
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter for latency/spacing measurements
    always @(posedge clk) cyc <= cyc + 1;

    // Single-ported memory model for instance a: read data one cycle after rd
    always @(posedge clk) begin
        if (a_wr) mem[a_addr] <= a_wr_data;
        if (a_rd) a_rd_data <= mem[a_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor for instance a
    always @(negedge clk) begin
        if (reset && (a_p0_ack || a_p1_ack)) begin
            if (qa.size() == 0) begin
                chk("a_unexpected_ack", {62'd0, a_p1_ack, a_p0_ack}, 64'd0);
            end else begin
                ea = qa.pop_front();
                chk("a_ack_port", {62'd0, a_p1_ack, a_p0_ack}, ea.port ? 64'd2 : 64'd1);
                chk("a_ack_rdata", {32'd0, (ea.port ? a_p1_rdata : a_p0_rdata)}, {32'd0, ea.rdata});
            end
        end
    end

    // Scoreboard monitor for instance b
    always @(negedge clk) begin
        if (reset && (b_p0_ack || b_p1_ack)) begin
            if (qb.size() == 0) begin
                chk("b_unexpected_ack", {62'd0, b_p1_ack, b_p0_ack}, 64'd0);
            end else begin
                eb = qb.pop_front();
                chk("b_ack_port", {62'd0, b_p1_ack, b_p0_ack}, eb.port ? 64'd2 : 64'd1);
                chk("b_ack_rdata", {32'd0, (eb.port ? b_p1_rdata : b_p0_rdata)}, {32'd0, eb.rdata});
            end
        end
    end

    // One isolated access on instance a with cycle-exact checks; call at a negedge while idle
    task automatic acc_a(input logic port, input logic we, input logic [8:0] ad,
                         input logic [31:0] wd, input logic [31:0] exp_rd);
        qa.push_back('{port: port, rdata: exp_rd});
        if (port) begin
            a_p1_we = we; a_p1_addr = ad; a_p1_wdata = wd; a_p1_req = 1'b1;
        end else begin
            a_p0_we = we; a_p0_addr = ad; a_p0_wdata = wd; a_p0_req = 1'b1;
        end
        #1;
        chk("stall_idle", {63'd0, (port ? a_p1_stall : a_p0_stall)}, 64'd1);
        @(negedge clk);
        chk("issue_strobe", {62'd0, a_wr, a_rd}, {62'd0, we, ~we});
        chk("issue_addr", {55'd0, a_addr}, {55'd0, ad});
        if (we) chk("issue_wdata", {32'd0, a_wr_data}, {32'd0, wd});
        chk("issue_owner", {62'd0, a_busy, a_grant_id}, {62'd0, 1'b1, port});
        chk("stall_issue", {63'd0, (port ? a_p1_stall : a_p0_stall)}, 64'd1);
        @(negedge clk);
        chk("resp_ack", {62'd0, a_p1_ack, a_p0_ack}, port ? 64'd2 : 64'd1);
        chk("stall_resp", {63'd0, (port ? a_p1_stall : a_p0_stall)}, 64'd0);
        chk("resp_strobe_low", {62'd0, a_wr, a_rd}, 64'd0);
        a_p0_req = 1'b0;
        a_p1_req = 1'b0;
        @(negedge clk);
        chk("idle_after", {61'd0, a_busy, a_p1_ack, a_p0_ack}, 64'd0);
    endtask

    // Short reset pulse, entered and left on negedges
    task automatic pulse_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    // Directed stimulus
    initial begin
        int n0;
        int n1;
        int got;
        int t0[$];
        int t1[$];
        checks = 0;
        errors = 0;
        cyc = 0;
        b_rd_data = 32'd0;
        a_p0_we = 1'b0; a_p0_addr = 9'd0; a_p0_wdata = 32'd0;
        a_p1_we = 1'b0; a_p1_addr = 9'd0; a_p1_wdata = 32'd0;
        b_p0_we = 1'b1; b_p0_addr = 9'd0; b_p0_wdata = 32'd0;
        b_p1_we = 1'b1; b_p1_addr = 9'd0; b_p1_wdata = 32'd0;
        a_p0_req = 1'b1; a_p1_req = 1'b1;
        b_p0_req = 1'b1; b_p1_req = 1'b1;
        reset = 1'b1;
        #1 reset = 1'b0;

        // 1: reset held with both requests high
        repeat (3) begin
            @(negedge clk);
            chk("rst_a_ctl", {49'd0, a_wr, a_rd, a_p0_ack, a_p1_ack, a_busy, a_grant_id, a_addr}, 64'd0);
            chk("rst_a_data", {a_p0_rdata, a_p1_rdata}, 64'd0);
            chk("rst_a_wdata", {32'd0, a_wr_data}, 64'd0);
            chk("rst_b_ctl", {49'd0, b_wr, b_rd, b_p0_ack, b_p1_ack, b_busy, b_grant_id, b_addr}, 64'd0);
        end
        a_p0_req = 1'b0; a_p1_req = 1'b0;
        b_p0_req = 1'b0; b_p1_req = 1'b0;
        reset = 1'b1;

        // 2: port 0 write then read back
        acc_a(1'b0, 1'b1, 9'h1A0, 32'hDEADBEEF, 32'd0);
        acc_a(1'b0, 1'b0, 9'h1A0, 32'd0, 32'hDEADBEEF);

        // 3: round-robin with both requests held
        pulse_reset();
        a_p0_we = 1'b1; a_p0_addr = 9'h010; a_p0_wdata = 32'h11111111;
        a_p1_we = 1'b1; a_p1_addr = 9'h020; a_p1_wdata = 32'h22222222;
        qa.push_back('{port: 1'b0, rdata: 32'd0});
        qa.push_back('{port: 1'b1, rdata: 32'd0});
        qa.push_back('{port: 1'b0, rdata: 32'd0});
        qa.push_back('{port: 1'b1, rdata: 32'd0});
        a_p0_req = 1'b1; a_p1_req = 1'b1;
        for (int i = 0; i < 40 && (t0.size() + t1.size()) < 4; i++) begin
            @(negedge clk);
            if (a_p0_ack) t0.push_back(cyc);
            if (a_p1_ack) t1.push_back(cyc);
        end
        a_p0_req = 1'b0; a_p1_req = 1'b0;
        chk("rr_acks_p0", 64'(t0.size()), 64'd2);
        chk("rr_acks_p1", 64'(t1.size()), 64'd2);
        if (t0.size() >= 2 && t1.size() >= 2) begin
            chk("rr_p0_spacing", 64'(t0[1] - t0[0]), 64'd6);
            chk("rr_p1_spacing", 64'(t1[1] - t1[0]), 64'd6);
            chk("rr_p1_after_p0", 64'(t1[0] - t0[0]), 64'd3);
        end
        @(negedge clk);

        // 5: reset pulled low during ISSUE of a port 1 write
        a_p1_we = 1'b1; a_p1_addr = 9'h0F0; a_p1_wdata = 32'h33333333; a_p1_req = 1'b1;
        @(negedge clk);
        chk("midrst_issue_wr", {63'd0, a_wr}, 64'd1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_wr_drop", {61'd0, a_wr, a_rd, a_busy}, 64'd0);
        a_p1_req = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("midrst_no_ack", {61'd0, a_busy, a_p1_ack, a_wr}, 64'd0);
        end

        // 6: port 1 read keeps its result through a port 0 write to the same word
        acc_a(1'b0, 1'b1, 9'h000, 32'hA5A5A5A5, 32'd0);
        acc_a(1'b1, 1'b0, 9'h000, 32'd0, 32'hA5A5A5A5);
        acc_a(1'b0, 1'b1, 9'h000, 32'h5A5A5A5A, 32'd0);
        chk("p1_rdata_held", {32'd0, a_p1_rdata}, {32'd0, 32'hA5A5A5A5});
        chk("p0_rdata_not_by_write", {32'd0, a_p0_rdata}, 64'd0);
        acc_a(1'b0, 1'b0, 9'h000, 32'd0, 32'h5A5A5A5A);
        chk("p1_rdata_held2", {32'd0, a_p1_rdata}, {32'd0, 32'hA5A5A5A5});

        // 4: fixed priority starves port 1 while port 0 keeps requesting
        b_p0_we = 1'b1; b_p0_addr = 9'h030; b_p0_wdata = 32'h44444444;
        b_p1_we = 1'b1; b_p1_addr = 9'h040; b_p1_wdata = 32'h55555555;
        for (int i = 0; i < 4; i++) qb.push_back('{port: 1'b0, rdata: 32'd0});
        b_p0_req = 1'b1; b_p1_req = 1'b1;
        n0 = 0; n1 = 0;
        for (int i = 0; i < 40 && n0 < 4; i++) begin
            @(negedge clk);
            if (b_p0_ack) n0++;
            if (b_p1_ack) n1++;
        end
        chk("fp_p0_acks", 64'(n0), 64'd4);
        chk("fp_p1_starved", 64'(n1), 64'd0);
        b_p0_req = 1'b0;
        qb.push_back('{port: 1'b1, rdata: 32'd0});
        got = 0;
        for (int i = 0; i < 10 && got == 0; i++) begin
            @(negedge clk);
            if (b_p1_ack) got = 1;
        end
        b_p1_req = 1'b0;
        chk("fp_p1_served", 64'(got), 64'd1);

        repeat (4) @(negedge clk);
        chk("qa_drained", 64'(qa.size()), 64'd0);
        chk("qb_drained", 64'(qb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
